// File: rtl/spi_flash_responder_pkg.sv
// Shared SPI definitions: flash opcodes, responder FSM states and status byte layout.
package spi_flash_responder_pkg;

    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_ADDR,
        ST_READ_DATA,
        ST_PROG_DATA,
        ST_STATUS,
        ST_IGNORE
    } state_t;

    // Status register: {reserved, WEL, WIP}; programming is instantaneous so WIP stays 0.
    function automatic logic [7:0] status_byte(input logic wel);
        return {6'b0, wel, 1'b0};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI pin, with rise/fall pulses on the synchronized level.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_p0, sync_p1, sync_p2;

    // p0/p1 form the synchronizer; p2 holds the previous synchronized level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
            sync_p2 <= RST_VAL;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign rise  = sync_p1 & ~sync_p2;
    assign fall  = ~sync_p1 & sync_p2;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash emulator (READ, PP, WREN, WRDI, RDSR) over an internal byte array, oversampled by clk.
module spi_flash_responder
    import spi_flash_responder_pkg::*;
#(
    parameter int MEM_ADDR_W = 12,
    parameter int PAGE_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_cs_n,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  busy,
    output logic                  cmd_error,
    input  logic                  bd_we,
    input  logic [MEM_ADDR_W-1:0] bd_addr,
    input  logic [7:0]            bd_wdata
);

    logic cs_lvl, cs_rise_unused, cs_fall;
    logic sck_lvl_unused, sck_rise, sck_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .din(spi_cs_n),
        .level(cs_lvl), .rise(cs_rise_unused), .fall(cs_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .din(spi_sck),
        .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(spi_mosi),
        .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    logic [7:0]            mem [2**MEM_ADDR_W];
    state_t                state;
    logic                  wel;
    logic                  is_prog;
    logic                  armed;
    logic [1:0]            flush_cnt;
    logic [4:0]            bit_cnt;
    logic [2:0]            tx_cnt;
    logic [7:0]            shift_in;
    logic [7:0]            tx_sr;
    logic [MEM_ADDR_W-1:0] addr;
    logic                  prog_we;
    logic [MEM_ADDR_W-1:0] prog_addr;
    logic [7:0]            prog_data;
    logic [7:0]            in_byte;
    logic [7:0]            rd_byte;
    logic [7:0]            st_byte;

    assign busy    = ~cs_lvl;
    assign in_byte = {shift_in[6:0], mosi_lvl};
    assign rd_byte = mem[addr];
    assign st_byte = status_byte(wel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wel       <= 1'b0;
            is_prog   <= 1'b0;
            armed     <= 1'b0;
            flush_cnt <= '0;
            bit_cnt   <= '0;
            tx_cnt    <= '0;
            shift_in  <= '0;
            tx_sr     <= '0;
            addr      <= '0;
            spi_miso  <= 1'b0;
            cmd_error <= 1'b0;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
        end else begin
            cmd_error <= 1'b0;
            prog_we   <= 1'b0;

            // After reset the cs synchronizer still holds its reset value; only arm once it
            // has flushed and seen CS high, so a transaction in flight during reset is ignored.
            if (flush_cnt != 2'd3) flush_cnt <= flush_cnt + 2'd1;
            else if (cs_lvl)       armed     <= 1'b1;

            if (cs_lvl) begin
                if (state != ST_IDLE && is_prog && wel) wel <= 1'b0;
                state    <= ST_IDLE;
                spi_miso <= 1'b0;
                is_prog  <= 1'b0;
                bit_cnt  <= '0;
                tx_cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall && armed) begin
                            state    <= ST_OPCODE;
                            bit_cnt  <= '0;
                            tx_cnt   <= '0;
                            shift_in <= '0;
                        end
                    end
                    ST_OPCODE: begin
                        if (sck_rise) begin
                            shift_in <= in_byte;
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                case (in_byte)
                                    OP_READ: state <= ST_ADDR;
                                    OP_PP: begin
                                        is_prog <= 1'b1;
                                        state   <= ST_ADDR;
                                    end
                                    OP_WREN: begin
                                        wel   <= 1'b1;
                                        state <= ST_IGNORE;
                                    end
                                    OP_WRDI: begin
                                        wel   <= 1'b0;
                                        state <= ST_IGNORE;
                                    end
                                    OP_RDSR: state <= ST_STATUS;
                                    default: begin
                                        cmd_error <= 1'b1;
                                        state     <= ST_IGNORE;
                                    end
                                endcase
                            end
                        end
                    end
                    ST_ADDR: begin
                        // Upper address bits simply shift out of the narrow register.
                        if (sck_rise) begin
                            addr    <= {addr[MEM_ADDR_W-2:0], mosi_lvl};
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= '0;
                                if (!is_prog) state <= ST_READ_DATA;
                                else if (wel) state <= ST_PROG_DATA;
                                else          state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_READ_DATA: begin
                        if (sck_fall) begin
                            if (tx_cnt == 3'd0) begin
                                spi_miso <= rd_byte[7];
                                tx_sr    <= {rd_byte[6:0], 1'b0};
                            end else begin
                                spi_miso <= tx_sr[7];
                                tx_sr    <= {tx_sr[6:0], 1'b0};
                            end
                            if (tx_cnt == 3'd7) addr <= addr + MEM_ADDR_W'(1);
                            tx_cnt <= tx_cnt + 3'd1;
                        end
                    end
                    ST_PROG_DATA: begin
                        if (sck_rise) begin
                            shift_in <= in_byte;
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt   <= '0;
                                prog_we   <= 1'b1;
                                prog_addr <= addr;
                                prog_data <= in_byte;
                                addr[PAGE_W-1:0] <= addr[PAGE_W-1:0] + PAGE_W'(1);
                            end
                        end
                    end
                    ST_STATUS: begin
                        if (sck_fall) begin
                            if (tx_cnt == 3'd0) begin
                                spi_miso <= st_byte[7];
                                tx_sr    <= {st_byte[6:0], 1'b0};
                            end else begin
                                spi_miso <= tx_sr[7];
                                tx_sr    <= {tx_sr[6:0], 1'b0};
                            end
                            tx_cnt <= tx_cnt + 3'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Storage has no reset; the backdoor port takes priority over a coincident SPI program write.
    always_ff @(posedge clk) begin
        if (bd_we)        mem[bd_addr]   <= bd_wdata;
        else if (prog_we) mem[prog_addr] <= prog_data;
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI mode-0 initiator driven at f_clk/10 with hand-computed expectations.
module tb_spi_flash_responder;

    localparam int HALF = 50;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_sck  = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        bd_we    = 1'b0;
    logic [11:0] bd_addr  = '0;
    logic [7:0]  bd_wdata = '0;
    logic        spi_miso;
    logic        busy;
    logic        cmd_error;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    int err_cycles = 0;
    int miso_hi    = 0;

    spi_flash_responder #(.MEM_ADDR_W(12), .PAGE_W(8)) dut (
        .clk(clk), .rst(rst),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .busy(busy), .cmd_error(cmd_error),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_error) err_cycles++;
        if (spi_miso)  miso_hi++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = tx[i];
            #HALF;
            rx[i]   = spi_miso;
            spi_sck = 1'b1;
            #HALF;
            spi_sck = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        xfer_bits(tx, 8, rx);
    endtask

    task automatic cs_start();
        spi_cs_n = 1'b0;
        #(2*HALF);
    endtask

    task automatic cs_end();
        #HALF;
        spi_cs_n = 1'b1;
        #(2*HALF);
    endtask

    task automatic bd_write(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_wdata = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic send_op_addr(input logic [7:0] op, input logic [23:0] a);
        logic [7:0] dummy;
        xfer(op, dummy);
        xfer(a[23:16], dummy);
        xfer(a[15:8], dummy);
        xfer(a[7:0], dummy);
    endtask

    task automatic read2(input logic [23:0] a, output logic [7:0] b0, output logic [7:0] b1);
        cs_start();
        send_op_addr(8'h03, a);
        xfer(8'h00, b0);
        xfer(8'h00, b1);
        cs_end();
    endtask

    task automatic simple_cmd(input logic [7:0] op);
        logic [7:0] dummy;
        cs_start();
        xfer(op, dummy);
        cs_end();
    endtask

    task automatic rdsr(output logic [7:0] s0, output logic [7:0] s1);
        logic [7:0] dummy;
        cs_start();
        xfer(8'h05, dummy);
        xfer(8'h00, s0);
        xfer(8'h00, s1);
        cs_end();
    endtask

    initial begin
        logic [7:0] r0, r1, dummy;
        int e0, m0;

        #1 rst = 1'b1;
        #20;
        check("rst_busy", busy, 1'b0);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_cmd_error", cmd_error, 1'b0);
        #13 rst = 1'b0;
        #200;

        bd_write(12'h001, 8'hA5);
        bd_write(12'h002, 8'h3C);
        bd_write(12'hFFF, 8'h5A);
        bd_write(12'h000, 8'hC3);
        bd_write(12'h010, 8'h99);
        bd_write(12'h020, 8'h44);

        // READ 0x001001: two sequential bytes, busy high only while CS is low
        cs_start();
        send_op_addr(8'h03, 24'h001001);
        xfer(8'h00, r0);
        xfer(8'h00, r1);
        check("read_busy_active", busy, 1'b1);
        cs_end();
        check("read_1001_b0", r0, 8'hA5);
        check("read_1001_b1", r1, 8'h3C);
        check("read_busy_idle", busy, 1'b0);

        // READ wrapping from the top of storage
        read2(24'h000FFF, r0, r1);
        check("read_fff_b0", r0, 8'h5A);
        check("read_wrap_b1", r1, 8'hC3);

        // unsupported opcode: single cmd_error cycle, MISO silent
        e0 = err_cycles;
        m0 = miso_hi;
        cs_start();
        xfer(8'hAB, dummy);
        xfer(8'hFF, dummy);
        cs_end();
        check("badop_err_cycles", err_cycles - e0, 1);
        check("badop_miso_quiet", miso_hi - m0, 0);

        rdsr(r0, r1);
        check("rdsr_initial", r0, 8'h00);

        // PP without WREN must not write
        cs_start();
        send_op_addr(8'h02, 24'h000010);
        xfer(8'h77, dummy);
        cs_end();
        read2(24'h000010, r0, r1);
        check("pp_nowren_unchanged", r0, 8'h99);

        simple_cmd(8'h06);
        rdsr(r0, r1);
        check("rdsr_wel_b0", r0, 8'h02);
        check("rdsr_wel_b1", r1, 8'h02);

        // PP with page wrap: 0x0FE, 0x0FF, then back to 0x000
        cs_start();
        send_op_addr(8'h02, 24'h0000FE);
        xfer(8'h11, dummy);
        xfer(8'h22, dummy);
        xfer(8'h33, dummy);
        cs_end();
        rdsr(r0, r1);
        check("rdsr_after_pp", r0, 8'h00);
        read2(24'h0000FE, r0, r1);
        check("pp_0fe", r0, 8'h11);
        check("pp_0ff", r1, 8'h22);
        read2(24'h000000, r0, r1);
        check("pp_000_wrap", r0, 8'h33);

        // abort mid-byte during PP: no write, busy drops within 3 clk, WEL cleared
        simple_cmd(8'h06);
        cs_start();
        send_op_addr(8'h02, 24'h000020);
        xfer_bits(8'hEE, 4, dummy);
        check("abort_busy_before", busy, 1'b1);
        spi_cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_3clk", busy, 1'b0);
        #(2*HALF);
        read2(24'h000020, r0, r1);
        check("abort_no_write", r0, 8'h44);
        rdsr(r0, r1);
        check("abort_wel_cleared", r0, 8'h00);

        // reset in the READ data phase: A5 = 1010_0101, after 2 bits MISO shows bit5 = 1
        cs_start();
        send_op_addr(8'h03, 24'h001001);
        xfer_bits(8'h00, 2, dummy);
        #30;
        check("rst_pre_miso", spi_miso, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_miso", spi_miso, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        #50;
        rst = 1'b0;
        #(2*HALF);
        spi_cs_n = 1'b1;
        #(2*HALF);
        read2(24'h000000, r0, r1);
        check("read_after_rst", r0, 8'h33);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
